// File: rtl/pipe_ctl.sv
// Pipeline hazard controller: stall/flush arbitration,
// per-register occupancy, stall watchdog and perf counters.
module pipe_ctl #(
  parameter int NSTAGE   = 5,
  parameter int CNTW     = 32,
  parameter int WDOG_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic [NSTAGE-1:0] flushreq,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] valid,
  output logic [CNTW-1:0]   stall_cycles,
  output logic [CNTW-1:0]   flush_events,
  output logic              wdog_err
);

  localparam int WW =
    (WDOG_CYC > 0) ? $clog2(WDOG_CYC + 1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(WDOG_CYC);
  localparam logic [WW-1:0] WPRE = WW'(WDOG_CYC - 1);
  localparam bit WEN = (WDOG_CYC > 0);

  int              k;
  int              f;
  logic            hs;
  logic            hf;
  logic            fl_ok;
  logic            any_stall;
  logic            any_flush;
  logic [NSTAGE-1:0] vsrc;
  logic [WW-1:0]   wd_cnt;

  // Oldest stall/flush requester wins; a stall at or
  // above the flushing stage blocks the redirect.
  always_comb begin
    stall  = '0;
    flush  = '0;
    bubble = '0;
    k      = 0;
    f      = 0;
    hs     = 1'b0;
    hf     = 1'b0;
    fl_ok  = 1'b0;
    for (int j = 1; j < NSTAGE; j++) begin
      if (stallreq[j]) begin
        k  = j;
        hs = 1'b1;
      end
      if (flushreq[j]) begin
        f  = j;
        hf = 1'b1;
      end
    end
    fl_ok = hf && !(hs && (k >= f));
    if (rst) begin
      for (int j = 0; j < NSTAGE; j++) begin
        stall[j]  = hs && (j <= k);
        bubble[j] = hs && (j == k + 1);
        flush[j]  = fl_ok && (j >= 1) && (j <= f);
      end
    end
  end

  assign any_stall = |stall;
  assign any_flush = |flush;
  assign vsrc      = {valid[NSTAGE-2:0], 1'b1};

  // Occupancy: hold on stall, clear on bubble/flush,
  // otherwise inherit from the previous register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else begin
      for (int j = 0; j < NSTAGE; j++) begin
        if (!stall[j]) begin
          valid[j] <= vsrc[j] & ~flush[j] & ~bubble[j];
        end
      end
    end
  end

  // Watchdog: saturating run length of stalled cycles,
  // sticky error once the run reaches the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (!any_stall || !WEN) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WMAX) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
      if (cnt_clr) begin
        wdog_err <= 1'b0;
      end else if (WEN && any_stall && wd_cnt >= WPRE) begin
        wdog_err <= 1'b1;
      end
    end
  end

  // Saturating perf counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (any_stall && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + CNTW'(1);
      end
      if (any_flush && flush_events != '1) begin
        flush_events <= flush_events + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl (NSTAGE=5, CNTW=4,
// WDOG_CYC=4) with hand-computed expectations.
module tb_pipe_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stallreq;
  logic [4:0] flushreq;
  logic       cnt_clr;
  logic [4:0] stall;
  logic [4:0] flush;
  logic [4:0] bubble;
  logic [4:0] valid;
  logic [3:0] stall_cycles;
  logic [3:0] flush_events;
  logic       wdog_err;

  int total = 0;
  int bad   = 0;

  pipe_ctl #(
    .NSTAGE(5),
    .CNTW(4),
    .WDOG_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq(stallreq),
    .flushreq(flushreq),
    .cnt_clr(cnt_clr),
    .stall(stall),
    .flush(flush),
    .bubble(bubble),
    .valid(valid),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill();
    stallreq = '0;
    flushreq = '0;
    repeat (5) tick();
  endtask

  logic [4:0] fill_exp;

  initial begin
    rst      = 1'b0;
    cnt_clr  = 1'b0;
    stallreq = '0;
    flushreq = '0;

    // T1 reset with random requests
    for (int i = 0; i < 3; i++) begin
      stallreq = 5'($urandom);
      flushreq = 5'($urandom);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_flush", flush, 0);
      chk("rst_bubble", bubble, 0);
      tick();
      chk("rst_valid", valid, 0);
      chk("rst_scyc", stall_cycles, 0);
      chk("rst_fev", flush_events, 0);
      chk("rst_wdog", wdog_err, 0);
    end
    stallreq = '0;
    flushreq = '0;
    rst      = 1'b1;
    fill_exp = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      fill_exp = {fill_exp[3:0], 1'b1};
      chk("fill_valid", valid, fill_exp);
    end

    // T2 load-use stall
    stallreq = 5'b00010;
    #1;
    chk("t2_stall", stall, 5'b00011);
    chk("t2_bubble", bubble, 5'b00100);
    chk("t2_flush", flush, 0);
    tick();
    stallreq = '0;
    chk("t2_valid", valid, 5'b11011);
    chk("t2_scyc", stall_cycles, 1);
    refill();
    chk("t2_refill", valid, 5'b11111);

    // T3 branch flush
    flushreq = 5'b00010;
    #1;
    chk("t3_flush", flush, 5'b00010);
    chk("t3_stall", stall, 0);
    tick();
    flushreq = '0;
    chk("t3_valid", valid, 5'b11101);
    chk("t3_fev", flush_events, 1);
    refill();

    // T4 stall blocks flush
    stallreq = 5'b00100;
    flushreq = 5'b00010;
    #1;
    chk("t4_stall", stall, 5'b00111);
    chk("t4_bubble", bubble, 5'b01000);
    chk("t4_flush_blk", flush, 0);
    tick();
    chk("t4_fev_hold", flush_events, 1);
    chk("t4_valid", valid, 5'b10111);
    stallreq = '0;
    #1;
    chk("t4_flush", flush, 5'b00010);
    tick();
    flushreq = '0;
    chk("t4_fev", flush_events, 2);
    chk("t4_valid2", valid, 5'b01101);

    // Boundaries: oldest flush wins, top stall,
    // stall at the flushing stage blocks it
    flushreq = 5'b01010;
    #1;
    chk("b_multi_flush", flush, 5'b01110);
    flushreq = '0;
    stallreq = 5'b10000;
    #1;
    chk("b_top_stall", stall, 5'b11111);
    chk("b_top_bubble", bubble, 0);
    stallreq = 5'b00100;
    flushreq = 5'b00100;
    #1;
    chk("b_eq_block", flush, 0);
    stallreq = 5'b00001;
    flushreq = 5'b00001;
    #1;
    chk("b_bit0_stall", stall, 0);
    chk("b_bit0_flush", flush, 0);
    stallreq = '0;
    flushreq = '0;

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_scyc", stall_cycles, 0);
    chk("clr_fev", flush_events, 0);
    refill();

    // T5 watchdog
    stallreq = 5'b00100;
    repeat (3) tick();
    chk("t5_wdog_3", wdog_err, 0);
    tick();
    chk("t5_wdog_4", wdog_err, 1);
    stallreq = '0;
    tick();
    chk("t5_wdog_sticky", wdog_err, 1);
    chk("t5_scyc", stall_cycles, 4);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_wdog_clr", wdog_err, 0);
    chk("t5_scyc_clr", stall_cycles, 0);

    // T6 saturation
    stallreq = 5'b00010;
    repeat (14) tick();
    chk("t6_scyc14", stall_cycles, 14);
    repeat (6) tick();
    chk("t6_sat", stall_cycles, 15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t6_clr_prio", stall_cycles, 0);
    tick();
    chk("t6_after_clr", stall_cycles, 1);

    // Reset mid-stall
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    tick();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_scyc", stall_cycles, 0);
    chk("mid_rst_wdog", wdog_err, 0);
    stallreq = '0;
    rst = 1'b1;
    tick();
    chk("mid_rst_pc", valid, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
